cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Coprocessor-0 style exception and interrupt controller for the single-cycle MIPS core.
- Successor to the fixed two-cause exception logic:
  - parametrised IRQ line count and handler vectors
  - prioritised causes: undefined, overflow, syscall, break, interrupt
  - Status, Cause and EPC registers, readable and writable via MFC0/MTC0
  - exception-level (EXL) state and ERET return
- Sits beside the PC mux. Drives the redirect target and the flush/squash of the current instruction.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines (1..8)
- UNDEF_VEC, `UNDEFINED_HANDLER_ADDR, handler address for undefined instruction
- OVF_VEC, `OVERFLOW_HANDLER_ADDR, handler address for arithmetic overflow
- GEN_VEC, 32'h0000_0180, handler address for syscall, break and interrupt

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- enable  in  1  core advance; state changes only when high
- control_undefined_instr  in  1  main decoder undefined flag
- alu_control_undefined_instr  in  1  ALU decoder undefined flag
- overflow  in  1  ALU signed overflow
- syscall  in  1  SYSCALL decoded
- brk  in  1  BREAK decoded
- eret  in  1  ERET decoded
- irq  in  NUM_IRQ  level-sensitive external interrupts
- pc_current  in  32  PC of the executing instruction
- cp0_we  in  1  MTC0 write strobe
- cp0_addr  in  5  CP0 register index (12 Status, 13 Cause, 14 EPC)
- cp0_wdata  in  32  MTC0 data
- cp0_rdata  out  32  MFC0 data, combinational
- take_exception  out  1  redirect PC to exception_vector; squash register/memory writes
- exception_vector  out  32  handler address
- take_eret  out  1  redirect PC to epc_reg
- epc_reg  out  32  EPC
- exl  out  1  Status.EXL

Behaviour:
- Reset values: epc_reg=0, Status=0 (IE=0, EXL=0, IM=0), Cause=0, irq_pending=0. With no inputs active all outputs are 0.
- Register layout:
  - Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM; other bits read 0.
  - Cause: bits[6:2] ExcCode, bits[8+NUM_IRQ-1:8] IP, bit31 BD=0.
- irq is registered once into irq_pending every cycle, so there is 1-cycle latency from irq to interrupt eligibility.
- Cause.IP mirrors irq_pending and is read-only.
- Cause selection, strict priority, combinational:
  - undefined (ctrl|alu): ExcCode 10, UNDEF_VEC
  - overflow: ExcCode 12, OVF_VEC
  - syscall: ExcCode 8, GEN_VEC
  - brk: ExcCode 9, GEN_VEC
  - interrupt: ExcCode 0, GEN_VEC. Eligible only when (irq_pending & IM)!=0, IE=1 and EXL=0.
- take_exception = enable & (any synchronous cause | eligible interrupt).
- On a clk edge with take_exception:
  - If EXL=0, epc_reg<=pc_current. If EXL=1 (nested), EPC is unchanged.
  - ExcCode is updated in all cases. EXL<=1.
- An interrupt is never taken in a cycle carrying a synchronous cause. It stays pending, and Cause.IP stays set.
- take_eret = enable & eret & ~take_exception. On that edge EXL<=0.
- eret with EXL=0 still redirects to epc_reg (software error, no trap).
- MTC0:
  - Writes Status (IE, EXL, IM) or EPC.
  - Writes to Cause, or to any other index, are ignored.
  - Applied only when enable & ~take_exception. If an exception occurs in the same cycle, the exception update wins and the write is dropped.
  - Same-cycle MTC0 to Status together with eret: ERET's EXL clear wins; IE and IM take the written values.
- MFC0: cp0_rdata reflects register contents before the edge. Unmapped indices read 0.
- enable=0: no register update except irq_pending sampling. take_exception and take_eret are forced 0.
- Reset asserted mid-handler: EXL cleared and EPC zeroed on the same edge. The core restarts at its reset PC.

Decomposition:
- Shared package sc_cp0_pkg holds:
  - CP0 register indices
  - ExcCode constants
  - Status/Cause bit positions
  - the GEN_VEC default
- Existing handler address macros stay in sc_mips_defines.svh.
- One sub-module, sc_exc_priority: a pure combinational encoder from cause flags to {valid, ExcCode, vector}.
- All state stays in the top module.

Test Plan:
- Undefined and overflow together, pc_current=0x0040_0010, EXL=0 -> take_exception=1, vector=UNDEF_VEC, ExcCode=10, EPC=0x0040_0010, EXL=1 next cycle.
- Status written 0x0000_0101 (IM0, IE), irq[0] raised at cycle N -> no trap at N, trap at N+1 with ExcCode=0, vector=0x180, EPC=PC at N+1.
- Same irq pending with EXL=1 -> no trap; after ERET, EXL=0 and the trap is taken the following cycle.
- Nested overflow with EXL=1, EPC=0x100 -> redirect to OVF_VEC, ExcCode=12, EPC stays 0x100.
- syscall plus MTC0 to EPC (0xDEAD_0000) in the same cycle -> EPC=pc_current, write dropped; with enable=0 the same stimulus -> no change, take_exception=0.
- Reset asserted while EXL=1, EPC=0x200 -> next cycle EXL=0, EPC=0, Cause=0, cp0_rdata(14)=0.

Source files
------------

// File: rtl/sc_cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, bit positions
// and the encoder's flag/result records.
package sc_cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int IM_LSB  = 8;
  localparam int EXC_LSB = 2;
  localparam int IP_LSB  = 8;

  localparam logic [31:0] GEN_VEC_DEFAULT = 32'h0000_0180;

  typedef struct packed {
    logic undef;
    logic ovf;
    logic sys;
    logic brk;
    logic intr;
  } exc_flags_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] vector;
  } exc_sel_t;

endpackage

// File: rtl/sc_exc_priority.sv
// Fixed-priority encoder from raised cause flags to {valid, ExcCode, vector}.
// Produces an all-zero result when no cause is raised.
module sc_exc_priority
  import sc_cp0_pkg::*;
#(
  parameter logic [31:0] UNDEF_VEC = 32'h0000_0000,
  parameter logic [31:0] OVF_VEC   = 32'h0000_0000,
  parameter logic [31:0] GEN_VEC   = GEN_VEC_DEFAULT
) (
  input  exc_flags_t flags_i,
  output exc_sel_t   sel_o
);

  // Priority chain: undefined > overflow > syscall > break > interrupt.
  always_comb begin
    sel_o = '0;
    if (flags_i.undef) begin
      sel_o.valid  = 1'b1;
      sel_o.code   = EXC_RI;
      sel_o.vector = UNDEF_VEC;
    end else if (flags_i.ovf) begin
      sel_o.valid  = 1'b1;
      sel_o.code   = EXC_OV;
      sel_o.vector = OVF_VEC;
    end else if (flags_i.sys) begin
      sel_o.valid  = 1'b1;
      sel_o.code   = EXC_SYS;
      sel_o.vector = GEN_VEC;
    end else if (flags_i.brk) begin
      sel_o.valid  = 1'b1;
      sel_o.code   = EXC_BP;
      sel_o.vector = GEN_VEC;
    end else if (flags_i.intr) begin
      sel_o.valid  = 1'b1;
      sel_o.code   = EXC_INT;
      sel_o.vector = GEN_VEC;
    end else begin
      sel_o = '0;
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt controller: Status, Cause and EPC state, cause
// prioritisation, PC redirect for traps and ERET, and MFC0/MTC0 access.
`ifndef UNDEFINED_HANDLER_ADDR
`define UNDEFINED_HANDLER_ADDR 32'h0000_0100
`endif
`ifndef OVERFLOW_HANDLER_ADDR
`define OVERFLOW_HANDLER_ADDR 32'h0000_0140
`endif

module cp0_exception_unit
  import sc_cp0_pkg::*;
#(
  parameter int          NUM_IRQ   = 6,
  parameter logic [31:0] UNDEF_VEC = `UNDEFINED_HANDLER_ADDR,
  parameter logic [31:0] OVF_VEC   = `OVERFLOW_HANDLER_ADDR,
  parameter logic [31:0] GEN_VEC   = GEN_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               control_undefined_instr,
  input  logic               alu_control_undefined_instr,
  input  logic               overflow,
  input  logic               syscall,
  input  logic               brk,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        pc_current,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               take_exception,
  output logic [31:0]        exception_vector,
  output logic               take_eret,
  output logic [31:0]        epc_reg,
  output logic               exl
);

  logic [31:0]        epc_q, epc_d;
  logic               ie_q, ie_d;
  logic               exl_q, exl_d;
  logic [NUM_IRQ-1:0] im_q, im_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [NUM_IRQ-1:0] irq_pending_q;
  logic               int_eligible_s;
  exc_flags_t         flags_s;
  exc_sel_t           sel_s;
  logic [31:0]        status_s;
  logic [31:0]        cause_s;

  // Interrupts are only eligible when unmasked, globally enabled and not already in a handler.
  assign int_eligible_s = (|(irq_pending_q & im_q)) & ie_q & ~exl_q;

  assign flags_s.undef = control_undefined_instr | alu_control_undefined_instr;
  assign flags_s.ovf   = overflow;
  assign flags_s.sys   = syscall;
  assign flags_s.brk   = brk;
  assign flags_s.intr  = int_eligible_s;

  sc_exc_priority #(
    .UNDEF_VEC (UNDEF_VEC),
    .OVF_VEC   (OVF_VEC),
    .GEN_VEC   (GEN_VEC)
  ) u_prio (
    .flags_i (flags_s),
    .sel_o   (sel_s)
  );

  assign take_exception   = enable & sel_s.valid;
  assign exception_vector = take_exception ? sel_s.vector : 32'h0000_0000;
  assign take_eret        = enable & eret & ~take_exception;
  assign epc_reg          = epc_q;
  assign exl              = exl_q;

  // Next-state: a trap beats MTC0; ERET's EXL clear beats an MTC0 to Status.
  always_comb begin
    epc_d      = epc_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    exc_code_d = exc_code_q;
    if (take_exception) begin
      if (!exl_q) begin
        epc_d = pc_current;
      end else begin
        epc_d = epc_q;
      end
      exc_code_d = sel_s.code;
      exl_d      = 1'b1;
    end else if (enable) begin
      if (cp0_we) begin
        case (cp0_addr)
          CP0_STATUS: begin
            ie_d  = cp0_wdata[ST_IE];
            exl_d = cp0_wdata[ST_EXL];
            im_d  = cp0_wdata[IM_LSB +: NUM_IRQ];
          end
          CP0_EPC: epc_d = cp0_wdata;
          default: ;
        endcase
      end else begin
        epc_d = epc_q;
      end
      if (take_eret) begin
        exl_d = 1'b0;
      end else begin
        exl_d = exl_d;
      end
    end else begin
      exc_code_d = exc_code_q;
    end
  end

  // State register; irq_pending samples every cycle regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q         <= 32'h0000_0000;
      ie_q          <= 1'b0;
      exl_q         <= 1'b0;
      im_q          <= '0;
      exc_code_q    <= 5'd0;
      irq_pending_q <= '0;
    end else begin
      epc_q         <= epc_d;
      ie_q          <= ie_d;
      exl_q         <= exl_d;
      im_q          <= im_d;
      exc_code_q    <= exc_code_d;
      irq_pending_q <= irq;
    end
  end

  // Architectural views of Status and Cause; unlisted bits read as zero.
  always_comb begin
    status_s                       = 32'h0000_0000;
    status_s[ST_IE]                = ie_q;
    status_s[ST_EXL]               = exl_q;
    status_s[IM_LSB +: NUM_IRQ]    = im_q;
    cause_s                        = 32'h0000_0000;
    cause_s[EXC_LSB +: 5]          = exc_code_q;
    cause_s[IP_LSB +: NUM_IRQ]     = irq_pending_q;
  end

  // MFC0 read mux.
  always_comb begin
    case (cp0_addr)
      CP0_STATUS: cp0_rdata = status_s;
      CP0_CAUSE:  cp0_rdata = cause_s;
      CP0_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: a table of single-cycle cause
// vectors from reset, then hand-written multi-cycle sequences.
module tb_cp0_exception_unit;

  localparam int          NIRQ    = 6;
  localparam logic [31:0] V_UNDEF = 32'h8000_0100;
  localparam logic [31:0] V_OVF   = 32'h8000_0140;
  localparam logic [31:0] V_GEN   = 32'h0000_0180;

  logic            clk = 1'b0;
  logic            reset, enable, ctrl_ud, alu_ud, ovf, sys, bk, er;
  logic [NIRQ-1:0] irq;
  logic [31:0]     pc;
  logic            we;
  logic [4:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata, vec, epc;
  logic            te, tr, exl_o;

  int n_cmp = 0;
  int n_err = 0;

  cp0_exception_unit #(
    .NUM_IRQ   (NIRQ),
    .UNDEF_VEC (V_UNDEF),
    .OVF_VEC   (V_OVF),
    .GEN_VEC   (V_GEN)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .enable                      (enable),
    .control_undefined_instr     (ctrl_ud),
    .alu_control_undefined_instr (alu_ud),
    .overflow                    (ovf),
    .syscall                     (sys),
    .brk                         (bk),
    .eret                        (er),
    .irq                         (irq),
    .pc_current                  (pc),
    .cp0_we                      (we),
    .cp0_addr                    (addr),
    .cp0_wdata                   (wdata),
    .cp0_rdata                   (rdata),
    .take_exception              (te),
    .exception_vector            (vec),
    .take_eret                   (tr),
    .epc_reg                     (epc),
    .exl                         (exl_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cu, au, ov, sc, bk, er;
    logic [31:0] pc;
    logic        x_te, x_tr;
    logic [31:0] x_vec;
    logic        x_exl;
    logic [31:0] x_epc;
    logic [31:0] x_cause;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ctrl_ud = 1'b0; alu_ud = 1'b0; ovf = 1'b0; sys = 1'b0; bk = 1'b0; er = 1'b0;
    we = 1'b0; addr = 5'd0; wdata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    //       cu    au    ov    sc    bk    er    pc            te    tr    vec      exl   epc           cause
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h00};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 1'b1, 1'b0, V_UNDEF, 1'b1, 32'h0040_0010, 32'h28};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0020, 1'b1, 1'b0, V_UNDEF, 1'b1, 32'h0040_0020, 32'h28};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, V_OVF,   1'b1, 32'h0000_1000, 32'h30};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 1'b1, 1'b0, V_GEN,   1'b1, 32'h0000_2000, 32'h20};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3004, 1'b1, 1'b0, V_GEN,   1'b1, 32'h0000_3004, 32'h24};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0,         32'h00};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0050, 1'b1, 1'b0, V_GEN,   1'b1, 32'h0000_0050, 32'h20};

    idle();
    enable = 1'b1; irq = '0; pc = 32'h0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_te", 32'(te), 32'h0);
    check("rst_tr", 32'(tr), 32'h0);
    check("rst_vec", vec, 32'h0);
    check("rst_exl", 32'(exl_o), 32'h0);
    check("rst_epc", epc, 32'h0);
    check_reg("rst_status", 5'd12, 32'h0);
    check_reg("rst_cause", 5'd13, 32'h0);
    check_reg("rst_unmapped", 5'd5, 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      ctrl_ud = tbl[i].cu; alu_ud = tbl[i].au; ovf = tbl[i].ov;
      sys = tbl[i].sc; bk = tbl[i].bk; er = tbl[i].er; pc = tbl[i].pc;
      #1;
      check($sformatf("v%0d_te", i), 32'(te), 32'(tbl[i].x_te));
      check($sformatf("v%0d_tr", i), 32'(tr), 32'(tbl[i].x_tr));
      check($sformatf("v%0d_vec", i), vec, tbl[i].x_vec);
      tick();
      idle();
      #1;
      check($sformatf("v%0d_exl", i), 32'(exl_o), 32'(tbl[i].x_exl));
      check($sformatf("v%0d_epc", i), epc, tbl[i].x_epc);
      check_reg($sformatf("v%0d_cause", i), 5'd13, tbl[i].x_cause);
    end

    // Interrupt latency and masking.
    do_reset();
    mtc0(5'd12, 32'h0000_0101);
    check_reg("irq_status", 5'd12, 32'h0000_0101);
    irq = 6'b000010; pc = 32'h0000_0ffc;
    tick();
    irq = 6'b000001; pc = 32'h0000_1000;
    #1;
    check("irq_masked_te", 32'(te), 32'h0);
    check_reg("irq_ip_masked", 5'd13, 32'h0000_0200);
    tick();
    pc = 32'h0000_1004;
    #1;
    check("irq_te", 32'(te), 32'h1);
    check("irq_vec", vec, V_GEN);
    tick();
    check("irq_exl", 32'(exl_o), 32'h1);
    check("irq_epc", epc, 32'h0000_1004);
    check_reg("irq_cause", 5'd13, 32'h0000_0100);

    // Pending interrupt held off by EXL, then taken after ERET.
    check("exl_block_te", 32'(te), 32'h0);
    er = 1'b1;
    #1;
    check("eret_tr", 32'(tr), 32'h1);
    tick();
    er = 1'b0;
    #1;
    check("eret_exl", 32'(exl_o), 32'h0);
    check_reg("eret_status", 5'd12, 32'h0000_0101);
    pc = 32'h0000_2000;
    #1;
    check("post_eret_te", 32'(te), 32'h1);
    tick();
    check("post_eret_epc", epc, 32'h0000_2000);

    // Nested overflow keeps EPC.
    irq = '0;
    mtc0(5'd14, 32'h0000_0100);
    check("nest_epc_wr", epc, 32'h0000_0100);
    ovf = 1'b1; pc = 32'h0000_3000;
    #1;
    check("nest_te", 32'(te), 32'h1);
    check("nest_vec", vec, V_OVF);
    tick();
    ovf = 1'b0;
    check("nest_epc", epc, 32'h0000_0100);
    check("nest_exl", 32'(exl_o), 32'h1);
    check_reg("nest_cause", 5'd13, 32'h0000_0030);

    // Syscall wins over a same-cycle MTC0; enable=0 freezes everything.
    do_reset();
    sys = 1'b1; we = 1'b1; addr = 5'd14; wdata = 32'hdead_0000; pc = 32'h0000_4000;
    tick();
    check("sys_epc", epc, 32'h0000_4000);
    enable = 1'b0; pc = 32'h0000_5000;
    #1;
    check("dis_te", 32'(te), 32'h0);
    tick();
    check("dis_epc", epc, 32'h0000_4000);
    idle();
    enable = 1'b1;
    check_reg("sys_cause", 5'd13, 32'h0000_0020);

    // MTC0 Status with ERET: EXL cleared, IE/IM written; Cause writes ignored.
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0203; er = 1'b1;
    #1;
    check("st_eret_tr", 32'(tr), 32'h1);
    tick();
    idle();
    check_reg("st_eret_status", 5'd12, 32'h0000_0201);
    mtc0(5'd13, 32'hffff_ffff);
    check_reg("cause_ro", 5'd13, 32'h0000_0020);

    // Reset in the middle of a handler.
    mtc0(5'd12, 32'h0000_0002);
    mtc0(5'd14, 32'h0000_0200);
    check("pre_rst_exl", 32'(exl_o), 32'h1);
    check("pre_rst_epc", epc, 32'h0000_0200);
    do_reset();
    check("mid_rst_exl", 32'(exl_o), 32'h0);
    check("mid_rst_epc", epc, 32'h0);
    check_reg("mid_rst_cause", 5'd13, 32'h0);
    check_reg("mid_rst_epc_rd", 5'd14, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
